// File: rtl/vga_display_if.sv
// Video timing bundle between the display core and its renderer/sink.
//   master : display core side (drives coordinates, strobes, syncs and colour)
//   slave  : renderer/sink side (drives en and per-pixel colour for x, y)
interface vga_display_if #(
  parameter int unsigned COLOR_W = 3,
  parameter int unsigned COORD_W = 11
);
  logic               en;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               pix_valid;
  logic               pix_ce;
  logic               hs;
  logic               vs;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               line_start;
  logic               frame_start;

  modport master (
    input  en, pix_r, pix_g, pix_b,
    output x, y, pix_valid, pix_ce, hs, vs, r, g, b, line_start, frame_start
  );

  modport slave (
    output en, pix_r, pix_g, pix_b,
    input  x, y, pix_valid, pix_ce, hs, vs, r, g, b, line_start, frame_start
  );
endinterface

// File: rtl/vga_display_core.sv
// VGA timing generator with a one-pixel registered colour/sync pipeline.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   vid  - vga_display_if.master: en and pix_r/g/b in; x, y, pix_valid, pix_ce,
//          hs, vs, r, g, b, line_start, frame_start out
// The display turns on/off only at frame end; counters and syncs always run.
module vga_display_core #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned COORD_W  = 11
) (
  input logic           clk,
  input logic           rst,
  vga_display_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {StOff, StOn} state_e;

  logic [DIV_W-1:0]   divQ, divD;
  logic               pixCeQ;
  logic [COORD_W-1:0] hcQ, hcD;
  logic [COORD_W-1:0] vcQ, vcD;
  state_e             stateQ, stateD;
  logic [COLOR_W-1:0] rQ, gQ, bQ;
  logic               hsQ, vsQ;
  logic               lineEnd, frameEnd, active, pixValid, hSync, vSync;

  always_comb begin
    divD     = (divQ == DIV_LAST) ? '0 : divQ + DIV_W'(1);
    lineEnd  = pixCeQ && (hcQ == H_LAST);
    frameEnd = lineEnd && (vcQ == V_LAST);
    hcD      = hcQ;
    vcD      = vcQ;
    stateD   = stateQ;
    if (pixCeQ) begin
      hcD = (hcQ == H_LAST) ? '0 : hcQ + COORD_W'(1);
    end
    if (lineEnd) begin
      vcD = (vcQ == V_LAST) ? '0 : vcQ + COORD_W'(1);
    end
    // en is only looked at on the last pixel strobe of a frame.
    if (frameEnd) begin
      stateD = vid.en ? StOn : StOff;
    end
    active   = (hcQ < H_ACT) && (vcQ < V_ACT);
    pixValid = (stateQ == StOn) && active;
    hSync    = (hcQ >= HS_BEG) && (hcQ < HS_END);
    vSync    = (vcQ >= VS_BEG) && (vcQ < VS_END);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      divQ   <= '0;
      pixCeQ <= 1'b0;
      hcQ    <= '0;
      vcQ    <= '0;
      stateQ <= StOff;
      rQ     <= '0;
      gQ     <= '0;
      bQ     <= '0;
      hsQ    <= ~HS_POL;
      vsQ    <= ~VS_POL;
    end else begin
      divQ   <= divD;
      // Registered strobe: first pix_ce lands CLK_DIV clocks after release,
      // and stays high permanently when CLK_DIV is 1.
      pixCeQ <= (divQ == DIV_LAST);
      hcQ    <= hcD;
      vcQ    <= vcD;
      stateQ <= stateD;
      if (pixCeQ) begin
        rQ  <= pixValid ? vid.pix_r : '0;
        gQ  <= pixValid ? vid.pix_g : '0;
        bQ  <= pixValid ? vid.pix_b : '0;
        hsQ <= ~(hSync ^ HS_POL);
        vsQ <= ~(vSync ^ VS_POL);
      end
    end
  end

  assign vid.x           = active ? hcQ : '0;
  assign vid.y           = active ? vcQ : '0;
  assign vid.pix_valid   = pixValid;
  assign vid.pix_ce      = pixCeQ;
  assign vid.hs          = hsQ;
  assign vid.vs          = vsQ;
  assign vid.r           = rQ;
  assign vid.g           = gQ;
  assign vid.b           = bQ;
  assign vid.line_start  = pixCeQ && (hcQ == '0);
  assign vid.frame_start = pixCeQ && (hcQ == '0) && (vcQ == '0);

endmodule

// File: tb/tb_vga_display_core.sv
// Directed bench for vga_display_core. Full default frames are too long to
// simulate, so frame-level behaviour runs on a scaled mode (uMid, CLK_DIV=2,
// H 16/2/4/2 = 24, V 10/2/2/2 = 16, 768 clk per frame); uDef keeps the default
// mode for reset and line timing; uSmall is the CLK_DIV=1 positive-sync mode.
module tb_vga_display_core;
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic colourMode;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_display_if ifDef ();
  vga_display_if ifMid ();
  vga_display_if ifSmall ();

  assign ifDef.en      = en;
  assign ifDef.pix_r   = 3'd7;
  assign ifDef.pix_g   = 3'd0;
  assign ifDef.pix_b   = 3'd5;
  assign ifMid.en      = en;
  assign ifMid.pix_r   = colourMode ? ifMid.x[2:0] : 3'd7;
  assign ifMid.pix_g   = colourMode ? ifMid.y[2:0] : 3'd0;
  assign ifMid.pix_b   = 3'd5;
  assign ifSmall.en    = en;
  assign ifSmall.pix_r = 3'd7;
  assign ifSmall.pix_g = 3'd0;
  assign ifSmall.pix_b = 3'd5;

  vga_display_core uDef (.clk(clk), .rst(rst), .vid(ifDef));

  vga_display_core #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) uMid (.clk(clk), .rst(rst), .vid(ifMid));

  vga_display_core #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) uSmall (.clk(clk), .rst(rst), .vid(ifSmall));

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within 50000 clocks");
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ifDef.hs;
      1:       return ifMid.hs;
      2:       return ifMid.vs;
      3:       return ifSmall.hs;
      default: return ifSmall.vs;
    endcase
  endfunction

  // Period and asserted width in clocks of the selected sync; -1 on timeout.
  task automatic measure(input int sel, input logic lvl, input int limit,
                         output int period, output int width);
    logic prev, cur;
    int n, p, w;
    period = -1;
    width  = -1;
    n      = 0;
    cur    = sig(sel);
    prev   = cur;
    while (n < limit && !(cur == lvl && prev != lvl)) begin
      prev = cur;
      @(negedge clk);
      cur = sig(sel);
      n++;
    end
    if (cur == lvl && prev != lvl) begin
      p = 0;
      w = 0;
      while (cur == lvl && p < limit) begin
        w++; p++; @(negedge clk); cur = sig(sel);
      end
      while (cur != lvl && p < limit) begin
        p++; @(negedge clk); cur = sig(sel);
      end
      if (p < limit) begin
        period = p;
        width  = w;
      end
    end
  endtask

  task automatic wait_xy(input int wx, input int wy, output bit ok);
    int n = 0;
    while (n < 2000 && !(ifMid.x == wx && ifMid.y == wy)) begin
      @(negedge clk);
      n++;
    end
    ok = (ifMid.x == wx && ifMid.y == wy);
  endtask

  task automatic wait_frame(output bit ok);
    int n = 0;
    while (n < 2000 && !ifMid.frame_start) begin
      @(negedge clk);
      n++;
    end
    ok = ifMid.frame_start;
  endtask

  task automatic wait_blank(output bit ok);
    int n = 0;
    while (n < 200 && ifMid.pix_valid) begin
      @(negedge clk);
      n++;
    end
    ok = !ifMid.pix_valid;
  endtask

  task automatic test_reset();
    logic [36:0] obs, want;
    logic [3:0]  obsO, wantO;
    rst = 1'b0; en = 1'b0; colourMode = 1'b0;
    want  = {4'b0000, 2'b11, 9'd0, 22'd0};
    wantO = {1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {ifMid.pix_ce, ifMid.line_start, ifMid.frame_start, ifMid.pix_valid,
             ifMid.hs, ifMid.vs, ifMid.r, ifMid.g, ifMid.b, ifMid.x, ifMid.y};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %h want %h", i, obs, want);
      end
      obsO = {ifSmall.pix_ce, ifSmall.hs, ifSmall.vs, ifSmall.frame_start};
      checks++;
      if (obsO !== 4'b0000) begin
        errors++;
        $display("FAIL reset_small cyc %0d got %b want 0000", i, obsO);
      end
      obsO = {ifDef.pix_ce, ifDef.hs, ifDef.vs, ifDef.frame_start};
      checks++;
      if (obsO !== wantO) begin
        errors++;
        $display("FAIL reset_def cyc %0d got %b want %b", i, obsO, wantO);
      end
    end
  endtask

  // Release with en=1: frame 0 stays dark, frame 1 shows the picture.
  task automatic test_first_frame();
    logic [3:0] obs;
    logic [8:0] rgb;
    int pv, zeros;
    rst = 1'b1; en = 1'b1;
    @(negedge clk);
    obs = {ifMid.pix_ce, ifDef.pix_ce, ifSmall.pix_ce, ifMid.frame_start};
    checks++;
    if (obs !== 4'b0010) begin
      errors++;
      $display("FAIL first_clk_after_release got %b want 0010", obs);
    end
    @(negedge clk);
    obs = {ifMid.pix_ce, ifMid.frame_start, ifMid.line_start, ifMid.pix_valid};
    checks++;
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL first_frame_start_mid got %b want 1110", obs);
    end
    obs = {ifDef.pix_ce, ifDef.frame_start, ifDef.line_start, ifDef.pix_valid};
    checks++;
    if (obs !== 4'b1110) begin
      errors++;
      $display("FAIL first_frame_start_def got %b want 1110", obs);
    end
    pv = 0; zeros = 0;
    for (int i = 0; i < 767; i++) begin
      if (ifMid.pix_valid !== 1'b0) pv++;
      if (ifSmall.pix_ce !== 1'b1) zeros++;
      @(negedge clk);
    end
    checks++;
    if (pv != 0) begin
      errors++;
      $display("FAIL valid_in_off_frame got %0d want 0", pv);
    end
    checks++;
    if (zeros != 0) begin
      errors++;
      $display("FAIL small_pix_ce_const got %0d low cycles want 0", zeros);
    end
    obs = {ifMid.pix_valid, ifMid.frame_start, 2'b00};
    checks++;
    if (obs !== 4'b1000 || ifMid.x !== 11'd0 || ifMid.y !== 11'd0 || ifMid.r !== 3'd0) begin
      errors++;
      $display("FAIL valid_rise got v/fs %b x %0d y %0d r %0d want 10 0 0 0",
               obs[3:2], ifMid.x, ifMid.y, ifMid.r);
    end
    @(negedge clk);
    checks++;
    if (ifMid.frame_start !== 1'b1 || ifMid.r !== 3'd0) begin
      errors++;
      $display("FAIL latency_1clk got fs %b r %0d want 1 0", ifMid.frame_start, ifMid.r);
    end
    @(negedge clk);
    rgb = {ifMid.r, ifMid.g, ifMid.b};
    checks++;
    if (rgb !== {3'd7, 3'd0, 3'd5}) begin
      errors++;
      $display("FAIL latency_2clk got %o want 705", rgb);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [8:0] rgb;
    wait_blank(ok);
    checks++;
    if (!ok || ifMid.r !== 3'd7) begin
      errors++;
      $display("FAIL last_active_pixel got ok %b r %0d want 1 7", ok, ifMid.r);
    end
    repeat (2) @(negedge clk);
    rgb = {ifMid.r, ifMid.g, ifMid.b};
    checks++;
    if (rgb !== 9'd0) begin
      errors++;
      $display("FAIL blank_rgb got %o want 000", rgb);
    end
  endtask

  task automatic test_pattern();
    bit ok;
    logic [8:0] rgb;
    colourMode = 1'b1;
    wait_xy(5, 3, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_5_3 got timeout want x=5 y=3");
    end
    @(negedge clk);
    rgb = {ifMid.r, ifMid.g, ifMid.b};
    checks++;
    if (rgb !== {3'd4, 3'd3, 3'd5}) begin
      errors++;
      $display("FAIL pattern_prev got %o want 435", rgb);
    end
    @(negedge clk);
    rgb = {ifMid.r, ifMid.g, ifMid.b};
    checks++;
    if (rgb !== {3'd5, 3'd3, 3'd5}) begin
      errors++;
      $display("FAIL pattern_cur got %o want 535", rgb);
    end
    wait_blank(ok);
    checks++;
    if (!ok || ifMid.x !== 11'd0 || ifMid.y !== 11'd0 || ifMid.hs !== 1'b1) begin
      errors++;
      $display("FAIL blank_xy got ok %b x %0d y %0d hs %b want 1 0 0 1",
               ok, ifMid.x, ifMid.y, ifMid.hs);
    end
  endtask

  task automatic test_counts();
    bit ok;
    int fs, ls;
    wait_frame(ok);
    fs = 0; ls = 0;
    for (int i = 0; i < 1536; i++) begin
      if (ifMid.frame_start === 1'b1) fs++;
      if (ifMid.line_start === 1'b1) ls++;
      @(negedge clk);
    end
    checks++;
    if (!ok || fs != 2 || ls != 32) begin
      errors++;
      $display("FAIL start_counts got fs %0d ls %0d want 2 32", fs, ls);
    end
  endtask

  task automatic test_sync();
    int p, w;
    measure(1, 1'b0, 4000, p, w);
    checks++;
    if (p != 48 || w != 8) begin
      errors++;
      $display("FAIL mid_hs got %0d/%0d want 48/8", p, w);
    end
    measure(2, 1'b0, 4000, p, w);
    checks++;
    if (p != 768 || w != 96) begin
      errors++;
      $display("FAIL mid_vs got %0d/%0d want 768/96", p, w);
    end
    measure(0, 1'b0, 4000, p, w);
    checks++;
    if (p != 1600 || w != 192) begin
      errors++;
      $display("FAIL def_hs got %0d/%0d want 1600/192", p, w);
    end
    measure(3, 1'b1, 4000, p, w);
    checks++;
    if (p != 14 || w != 2) begin
      errors++;
      $display("FAIL small_hs got %0d/%0d want 14/2", p, w);
    end
    measure(4, 1'b1, 4000, p, w);
    checks++;
    if (p != 98 || w != 14) begin
      errors++;
      $display("FAIL small_vs got %0d/%0d want 98/14", p, w);
    end
  endtask

  task automatic test_en_drop();
    bit ok, ok2;
    int pv, rn, p, w;
    colourMode = 1'b0;
    wait_xy(0, 5, ok);
    en = 1'b0;
    wait_xy(3, 8, ok2);
    checks++;
    if (!ok || !ok2 || ifMid.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_drop_persist got valid %b want 1", ifMid.pix_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ifMid.r !== 3'd7) begin
      errors++;
      $display("FAIL en_drop_colour got r %0d want 7", ifMid.r);
    end
    wait_frame(ok);
    pv = 0; rn = 0;
    for (int i = 0; i < 760; i++) begin
      if (ifMid.pix_valid !== 1'b0) pv++;
      if ({ifMid.r, ifMid.g, ifMid.b} !== 9'd0) rn++;
      @(negedge clk);
    end
    checks++;
    if (!ok || pv != 0 || rn != 0) begin
      errors++;
      $display("FAIL off_frame_dark got valid %0d rgb %0d want 0 0", pv, rn);
    end
    measure(1, 1'b0, 4000, p, w);
    checks++;
    if (p != 48 || w != 8) begin
      errors++;
      $display("FAIL off_hs got %0d/%0d want 48/8", p, w);
    end
    measure(2, 1'b0, 4000, p, w);
    checks++;
    if (p != 768 || w != 96) begin
      errors++;
      $display("FAIL off_vs got %0d/%0d want 768/96", p, w);
    end
    wait_xy(0, 5, ok);
    en = 1'b1;
    wait_xy(3, 8, ok2);
    checks++;
    if (!ok || !ok2 || ifMid.pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_rise_midframe got valid %b want 0", ifMid.pix_valid);
    end
    wait_frame(ok);
    checks++;
    if (!ok || ifMid.pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL en_rise_frame got valid %b want 1", ifMid.pix_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [36:0] obs, want;
    logic [3:0]  o;
    want = {4'b0000, 2'b11, 9'd0, 22'd0};
    wait_xy(10, 6, ok);
    checks++;
    if (!ok || ifMid.r !== 3'd7) begin
      errors++;
      $display("FAIL pre_reset got ok %b r %0d want 1 7", ok, ifMid.r);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {ifMid.pix_ce, ifMid.line_start, ifMid.frame_start, ifMid.pix_valid,
             ifMid.hs, ifMid.vs, ifMid.r, ifMid.g, ifMid.b, ifMid.x, ifMid.y};
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL midreset_mid cyc %0d got %h want %h", i, obs, want);
      end
      o = {ifSmall.pix_ce, ifSmall.hs, ifSmall.vs, ifDef.hs};
      checks++;
      if (o !== 4'b0001) begin
        errors++;
        $display("FAIL midreset_other cyc %0d got %b want 0001", i, o);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifMid.pix_ce !== 1'b0 || ifMid.x !== 11'd0 || ifMid.y !== 11'd0) begin
      errors++;
      $display("FAIL post_reset_1 got ce %b x %0d y %0d want 0 0 0",
               ifMid.pix_ce, ifMid.x, ifMid.y);
    end
    @(negedge clk);
    o = {ifMid.pix_ce, ifMid.frame_start, ifMid.line_start, ifMid.pix_valid};
    checks++;
    if (o !== 4'b1110) begin
      errors++;
      $display("FAIL post_reset_frame got %b want 1110", o);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_blanking();
    test_pattern();
    test_counts();
    test_sync();
    test_en_drop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
